// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
// Optional build macro used by this slice: SERIAL_ADD_SUB_EN (adds a subtract mode).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit operand still needs a one-bit counter, so the width never drops to zero.
    function automatic int countWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int COUNT_W = countWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_add_dp.sv
// Datapath of the serial adder: operand shift registers, carry flop,
// partial-sum shift register and the single full-adder cell.
module serial_add_dp
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sumNext,
    output logic             o_carryNext
);

    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic             w_bit;
    logic [WIDTH-1:0] w_psumNext;

    assign w_bit       = r_opA[0] ^ r_opB[0] ^ r_carry;
    assign o_carryNext = (r_opA[0] & r_opB[0]) | (r_opA[0] & r_carry) | (r_opB[0] & r_carry);

    // Each new bit enters at the MSB, so after WIDTH steps the LSB-first bits are in place.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign w_psumNext = w_bit;
        end else begin : g_wide
            assign w_psumNext = {w_bit, r_psum[WIDTH-1:1]};
        end
    endgenerate

    assign o_sumNext = w_psumNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_opA   <= i_a;
            r_opB   <= i_b;
            r_psum  <= '0;
            r_carry <= i_cin;
        end else if (i_step) begin
            r_opA   <= r_opA >> 1;
            r_opB   <= r_opB >> 1;
            r_psum  <= w_psumNext;
            r_carry <= o_carryNext;
        end
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: FSM, bit counter and held result registers.
// Define SERIAL_ADD_SUB_EN to add the `sub` input (a - b via ~b and forced carry-in).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = countWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CW-1:0]    r_count;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_bLoad;
    logic             w_cinLoad;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_carryNext;

`ifdef SERIAL_ADD_SUB_EN
    assign w_bLoad   = sub ? ~b : b;
    assign w_cinLoad = sub | cin;
`else
    assign w_bLoad   = b;
    assign w_cinLoad = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (start) w_stateNext = RUN;
            RUN:     if (r_count == LAST) w_stateNext = DONE;
            DONE:    w_stateNext = start ? RUN : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // A start is only honoured while ready; requests during RUN are dropped.
    always_comb begin
        busy     = (r_state == RUN);
        done     = (r_state == DONE);
        w_step   = (r_state == RUN);
        w_last   = (r_state == RUN) && (r_count == LAST);
        w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The result is written only on the final bit, so partial sums never reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (w_last) begin
            sum  <= w_sumNext;
            cout <= w_carryNext;
        end
    end

    serial_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_a        (a),
        .i_b        (w_bLoad),
        .i_cin      (w_cinLoad),
        .o_sumNext  (w_sumNext),
        .o_carryNext(w_carryNext)
    );

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 plus a WIDTH=1 instance).
// Define SERIAL_ADD_SUB_EN to also exercise subtract mode.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } result_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
    logic         sub1;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic start1, a1, b1, cin1, busy1, done1, sum1, cout1;

    result_t    expQ[$];
    logic [1:0] expQ1[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub1),
`endif
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
        .cout (cout1)
    );

    // Drives a one-cycle start at a falling edge and records the expected result.
    task automatic startOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opCin);
        logic [W:0] t;
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        cin   = opCin;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        t = {1'b0, opA} + {1'b0, opB} + {{W{1'b0}}, opCin};
        expQ.push_back('{sum: t[W-1:0], cout: t[W]});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitors from the first RUN cycle (index 1) until done or the budget expires.
    task automatic waitDone(input int budget, output int cycles, output int busyCycles,
                            output bit sumChanged, output bit seen);
        logic [W-1:0] sum0;
        logic         cout0;
        sum0 = sum;
        cout0 = cout;
        cycles = 1;
        busyCycles = 0;
        sumChanged = 1'b0;
        seen = 1'b0;
        while (cycles <= budget) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            if (sum !== sum0 || cout !== cout0) sumChanged = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state busy=%0b done=%0b sum=%h cout=%0b expected all zero",
                     busy, done, sum, cout);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_state_w1 got=%b expected 0000", {busy1, done1, sum1, cout1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, bc;
        bit chg, seen;
        result_t e;
        startOp(8'h5A, 8'h3C, 1'b0);
        waitDone(20, cyc, bc, chg, seen);
        checks++;
        if (!seen || cyc != 9) begin
            failures++;
            $display("[TB] FAIL basic_latency seen=%0b cycle=%0d expected done at cycle 9", seen, cyc);
        end
        checks++;
        if (bc != 8) begin
            failures++;
            $display("[TB] FAIL basic_busy busy_cycles=%0d expected 8", bc);
        end
        checks++;
        if (chg) begin
            failures++;
            $display("[TB] FAIL basic_hold sum/cout changed before done");
        end
        e = expQ.pop_front();
        checks++;
        if (sum !== e.sum || cout !== e.cout || sum !== 8'h96) begin
            failures++;
            $display("[TB] FAIL basic_result sum=%h cout=%0b expected sum=%h cout=%0b",
                     sum, cout, e.sum, e.cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== e.sum) begin
            failures++;
            $display("[TB] FAIL basic_after_done done=%0b busy=%0b sum=%h expected 0 0 %h",
                     done, busy, sum, e.sum);
        end
    endtask

    task automatic test_carry();
        int cyc, bc;
        bit chg, seen;
        result_t e;
        logic [W-1:0] va[2] = '{8'hFF, 8'h00};
        logic [W-1:0] vb[2] = '{8'h01, 8'h00};
        logic         vc[2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            startOp(va[i], vb[i], vc[i]);
            waitDone(20, cyc, bc, chg, seen);
            e = expQ.pop_front();
            checks++;
            if (!seen || sum !== e.sum || cout !== e.cout) begin
                failures++;
                $display("[TB] FAIL carry_%0d seen=%0b sum=%h cout=%0b expected sum=%h cout=%0b",
                         i, seen, sum, cout, e.sum, e.cout);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        bit chg, seen;
        result_t e;
        logic [W:0] t;
        @(negedge clk);
        start = 1'b1; a = 8'h21; b = 8'h13; cin = 1'b1;
        t = {1'b0, a} + {1'b0, b} + 9'd1;
        expQ.push_back('{sum: t[W-1:0], cout: t[W]});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 8'hF0 + 8'(i); b = 8'hEE; cin = 1'b0;
        end
        start = 1'b0;
        waitDone(20, cyc, bc, chg, seen);
        e = expQ.pop_front();
        checks++;
        if (!seen || sum !== e.sum || cout !== e.cout) begin
            failures++;
            $display("[TB] FAIL ignore_busy seen=%0b sum=%h cout=%0b expected sum=%h cout=%0b",
                     seen, sum, cout, e.sum, e.cout);
        end
        start = 1'b1; a = 8'hC3; b = 8'h4E; cin = 1'b1;
        t = {1'b0, a} + {1'b0, b} + 9'd1;
        expQ.push_back('{sum: t[W-1:0], cout: t[W]});
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_busy_rise done=%0b busy=%0b expected 0 1", done, busy);
        end
        waitDone(20, cyc, bc, chg, seen);
        e = expQ.pop_front();
        checks++;
        if (!seen || cyc != 9 || chg) begin
            failures++;
            $display("[TB] FAIL b2b_latency seen=%0b cycle=%0d changed=%0b expected 1 9 0", seen, cyc, chg);
        end
        checks++;
        if (sum !== e.sum || cout !== e.cout) begin
            failures++;
            $display("[TB] FAIL b2b_result sum=%h cout=%0b expected sum=%h cout=%0b",
                     sum, cout, e.sum, e.cout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc, doneSeen;
        bit chg, seen;
        result_t e;
        startOp(8'h77, 8'h99, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        void'(expQ.pop_back());
        checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_outputs busy=%0b done=%0b sum=%h cout=%0b expected all zero",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checks++;
        if (doneSeen != 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_no_done done_pulses=%0d busy=%0b expected 0 0", doneSeen, busy);
        end
        startOp(8'hA5, 8'h5B, 1'b0);
        waitDone(20, cyc, bc, chg, seen);
        e = expQ.pop_front();
        checks++;
        if (!seen || cyc != 9 || sum !== e.sum || cout !== e.cout) begin
            failures++;
            $display("[TB] FAIL abort_recover seen=%0b cycle=%0d sum=%h cout=%0b expected 9 %h %0b",
                     seen, cyc, sum, cout, e.sum, e.cout);
        end
        @(negedge clk);
    endtask

    task automatic test_width1();
        int cyc;
        logic [1:0] e;
        logic [2:0] v;
        for (int i = 7; i >= 0; i--) begin
            v = 3'(i);
            @(negedge clk);
            start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
            expQ1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            @(negedge clk);
            start1 = 1'b0;
            cyc = 1;
            while (!done1 && cyc <= 10) begin
                @(negedge clk);
                cyc++;
            end
            e = expQ1.pop_front();
            checks++;
            if (!done1 || cyc != 2 || {cout1, sum1} !== e) begin
                failures++;
                $display("[TB] FAIL width1_%0d done=%0b cycle=%0d cout,sum=%b expected cycle 2 %b",
                         i, done1, cyc, {cout1, sum1}, e);
            end
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int cyc, bc;
        bit chg, seen;
        result_t e;
        logic [W:0] t;
        logic [W-1:0] va[2] = '{8'h10, 8'h01};
        logic [W-1:0] vb[2] = '{8'h01, 8'h02};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1; a = va[i]; b = vb[i]; cin = 1'b0; sub = 1'b1;
            t = {1'b0, va[i]} + {1'b0, ~vb[i]} + 9'd1;
            expQ.push_back('{sum: t[W-1:0], cout: t[W]});
            @(negedge clk);
            start = 1'b0; sub = 1'b0;
            waitDone(20, cyc, bc, chg, seen);
            e = expQ.pop_front();
            checks++;
            if (!seen || sum !== e.sum || cout !== e.cout) begin
                failures++;
                $display("[TB] FAIL sub_%0d seen=%0b sum=%h cout=%0b expected sum=%h cout=%0b",
                         i, seen, sum, cout, e.sum, e.cout);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        checks++;
        if (expQ.size() != 0 || expQ1.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain left=%0d/%0d expected 0", expQ.size(), expQ1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
